// File: rtl/adder_accum_ctrl.sv
// Operand accumulator around an external combinational adder: sums a streamed packet and
// presents the total, a sticky signed-overflow flag, and saturating carry and beat counts.
module adder_accum_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] add_A,
    output logic [WIDTH-1:0] add_B,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    input  logic             add_of,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_of,
    output logic [CNT_W-1:0] out_carries,
    output logic [CNT_W-1:0] out_beats
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             of_q;
    logic [CNT_W-1:0] carries_q, carries_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             fire;

    assign fire    = in_valid && in_ready_q;
    assign add_A   = acc_q;
    assign add_B   = in_data;
    assign add_cin = 1'b0;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        carries_d = carries_q;
        beats_d   = beats_q;
        if (add_cout && (carries_q != CNT_MAX)) carries_d = carries_q + CNT_W'(1);
        if (beats_q != CNT_MAX)                 beats_d   = beats_q + CNT_W'(1);
    end

    // NOTE: state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            of_q        <= 1'b0;
            carries_q   <= '0;
            beats_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (fire) begin
                        acc_q     <= add_sum;
                        of_q      <= of_q | add_of;
                        carries_q <= carries_d;
                        beats_q   <= beats_d;
                        if (in_last) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Handshake clears the result so the next packet starts from zero.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        of_q        <= 1'b0;
                        carries_q   <= '0;
                        beats_q     <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = acc_q;
    assign out_of      = of_q;
    assign out_carries = carries_q;
    assign out_beats   = beats_q;

endmodule
